bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 137 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Feeds the seven-segment display driver with a packed 4-digit BCD word. BCD and ovf
// only change on the completing edge, so the display never sees a partial result.
// Optional build macro: BIN_TO_BCD_AUTO_EN -- when defined, a conversion also starts
// automatically whenever bin differs from the last converted value.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      BCD,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t           state_r;
  logic [BIN_W-1:0] shift_r;
  logic [15:0]      scratch_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_pend_r;

  logic             over_s;
  logic [BIN_W-1:0] clamp_s;
  logic [15:0]      scratch_nxt_s;
  logic [BIN_W-1:0] shift_nxt_s;
  logic             accept_s;

`ifdef BIN_TO_BCD_AUTO_EN
  logic [BIN_W-1:0] last_r;
`endif

  // Add 3 to a digit nibble that is 5 or more, so the following shift carries correctly.
  function automatic logic [3:0] add3_fn(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // One double-dabble step on the scratch digits: adjust every nibble, then shift in_bit in.
  // The top nibble's bit 3 is shifted out; it is always zero for results up to 9999.
  function automatic logic [15:0] dabble_fn(input logic [15:0] scr, input logic in_bit);
    return {3'(add3_fn(scr[15:12])), add3_fn(scr[11:8]), add3_fn(scr[7:4]),
            add3_fn(scr[3:0]), in_bit};
  endfunction

  // Input clamping, accept decision and next-step datapath values.
  always_comb begin
    over_s = (32'(bin) > 32'(MAX_VAL));
    if (over_s) begin
      clamp_s = MAX_BIN;
    end else begin
      clamp_s = bin;
    end
    scratch_nxt_s = dabble_fn(scratch_r, shift_r[BIN_W-1]);
    shift_nxt_s   = {shift_r[BIN_W-2:0], 1'b0};
`ifdef BIN_TO_BCD_AUTO_EN
    accept_s = start | (bin != last_r);
`else
    accept_s = start;
`endif
  end

  // Control FSM and datapath registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {BIN_W{1'b0}};
      scratch_r  <= 16'h0000;
      cnt_r      <= {CNT_W{1'b0}};
      ovf_pend_r <= 1'b0;
      BCD        <= 16'h0000;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef BIN_TO_BCD_AUTO_EN
      last_r     <= {BIN_W{1'b0}};
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shift_r    <= clamp_s;
            ovf_pend_r <= over_s;
            scratch_r  <= 16'h0000;
            cnt_r      <= {CNT_W{1'b0}};
            busy       <= 1'b1;
            state_r    <= CONV;
`ifdef BIN_TO_BCD_AUTO_EN
            last_r     <= bin;
`endif
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CONV: begin
          scratch_r <= scratch_nxt_s;
          shift_r   <= shift_nxt_s;
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            BCD     <= scratch_nxt_s;
            ovf     <= ovf_pend_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= CONV;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default build, BIN_W=14, MAX_VAL=9999).
// Expected BCD is computed with decimal arithmetic on the clamped input value.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] BCD;
  logic        ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_bcd = 16'h0000;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk  (clk),
    .rst  (rst),
    .bin  (bin),
    .start(start),
    .busy (busy),
    .done (done),
    .BCD  (BCD),
    .ovf  (ovf)
  );

  // Reference: clamp, then split into decimal digits.
  function automatic logic [15:0] bcd_model(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return 16'(((c / 1000) << 12) | (((c / 100) % 10) << 8) | (((c / 10) % 10) << 4) | (c % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion of v; glitch_at >= 0 pulses start with a different bin mid-conversion.
  task automatic convert(input int v, input int glitch_at);
    int   cyc;
    logic seen;
    @(negedge clk);
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 30) begin
      chk("busy", 32'(busy), 32'd1);
      chk("hold_bcd", 32'(BCD), 32'(exp_bcd));
      chk("hold_ovf", 32'(ovf), 32'(exp_ovf));
      if (cyc == glitch_at) begin
        bin   = 14'(v + 300);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    exp_bcd = bcd_model(v);
    exp_ovf = (v > 9999);
    chk("latency", 32'(cyc), 32'(BIN_W));
    chk("bcd", 32'(BCD), 32'(exp_bcd));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    if (glitch_at >= 0) begin
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
      end
      chk("no_second_done", 32'(seen), 32'd0);
      chk("glitch_bcd", 32'(BCD), 32'(exp_bcd));
    end
  endtask

  initial begin
    logic seen;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 14'd0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(BCD), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    convert(1234, -1);
    convert(0, -1);
    convert(9999, -1);
    convert(7, -1);
    convert(12000, -1);
    convert(42, -1);
    convert(10000, -1);
    convert(16383, -1);
    convert(9998, -1);
    convert(500, 3);
    for (int i = 0; i < 15; i++) begin
      convert(int'($urandom_range(0, 16383)), -1);
    end

    // Reset in the middle of a conversion aborts it without a done pulse.
    @(negedge clk);
    bin   = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bcd", 32'(BCD), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    rst     = 1'b0;
    exp_bcd = 16'h0000;
    exp_ovf = 1'b0;
    seen    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    convert(8765, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
